// File: rtl/led_pwm_pkg.sv
// Shared types and helpers for the LED PWM bank: channel mode encoding and
// the channel-index width.
package led_pwm_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_PWM   = 2'd2,
    MODE_BLINK = 2'd3
  } led_mode_e;

  function automatic int unsigned chan_idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: active config, blink frame counter/phase and the
// registered PWM compare.
module led_pwm_channel
  import led_pwm_pkg::*;
#(
  parameter int unsigned PWM_WIDTH   = 8,
  parameter int unsigned BLINK_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   frame_edge_i,
  input  logic                   apply_i,
  input  led_mode_e              mode_i,
  input  logic [PWM_WIDTH-1:0]   duty_i,
  input  logic [BLINK_WIDTH-1:0] blink_i,
  input  logic [PWM_WIDTH-1:0]   cnt_i,
  output logic                   led_o
);

  led_mode_e              mode_q;
  logic [PWM_WIDTH-1:0]   duty_q;
  logic [BLINK_WIDTH-1:0] blink_q;
  logic [BLINK_WIDTH-1:0] fcnt_q, fcnt_d;
  logic                   phase_q, phase_d;
  logic                   led_q, led_d;

  always_comb begin
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    // blink=0 pins the phase on so BLINK degenerates to plain PWM
    if (mode_q == MODE_BLINK) begin
      if (blink_q == '0) begin
        fcnt_d  = '0;
        phase_d = 1'b1;
      end else if (fcnt_q == blink_q - BLINK_WIDTH'(1)) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + BLINK_WIDTH'(1);
      end
    end
  end

  always_comb begin
    led_d = 1'b0;
    unique case (mode_q)
      MODE_OFF:   led_d = 1'b0;
      MODE_ON:    led_d = 1'b1;
      MODE_PWM:   led_d = (cnt_i < duty_q);
      MODE_BLINK: led_d = (cnt_i < duty_q) && phase_q;
      default:    led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mode_q  <= MODE_OFF;
      duty_q  <= '0;
      blink_q <= '0;
      fcnt_q  <= '0;
      phase_q <= 1'b1;
      led_q   <= 1'b0;
    end else begin
      led_q <= led_d;
      if (frame_edge_i) begin
        if (apply_i) begin
          mode_q  <= mode_i;
          duty_q  <= duty_i;
          blink_q <= blink_i;
          fcnt_q  <= '0;
          phase_q <= 1'b1;
        end else begin
          fcnt_q  <= fcnt_d;
          phase_q <= phase_d;
        end
      end
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/led_pwm_bank.sv
// Bank of PWM/blink LED channels sharing one prescaler and PWM counter.
// Config writes are staged and applied only at frame boundaries.
module led_pwm_bank
  import led_pwm_pkg::*;
#(
  parameter int unsigned CHANNELS    = 8,
  parameter int unsigned PWM_WIDTH   = 8,
  parameter int unsigned PRESCALE    = 16,
  parameter int unsigned BLINK_WIDTH = 8
) (
  input  logic                                  io_mainClk,
  input  logic                                  io_resetn,
  input  logic                                  io_cfg_valid,
  output logic                                  io_cfg_ready,
  input  logic [chan_idx_width(CHANNELS)-1:0]   io_cfg_channel,
  input  logic [1:0]                            io_cfg_mode,
  input  logic [PWM_WIDTH-1:0]                  io_cfg_duty,
  input  logic [BLINK_WIDTH-1:0]                io_cfg_blink,
  output logic [CHANNELS-1:0]                   io_led,
  output logic                                  io_frame
);

  localparam int unsigned CW    = chan_idx_width(CHANNELS);
  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PRE_W-1:0]       pre_q;
  logic [PWM_WIDTH-1:0]   cnt_q;
  logic                   frame_q;
  logic                   pend_q;
  logic [CW-1:0]          stage_ch_q;
  led_mode_e              stage_mode_q;
  logic [PWM_WIDTH-1:0]   stage_duty_q;
  logic [BLINK_WIDTH-1:0] stage_blink_q;

  logic tick, boundary, accept;

  assign tick     = (pre_q == PRE_W'(PRESCALE - 1));
  assign boundary = tick && (cnt_q == '1);
  assign accept   = io_cfg_valid && !pend_q;

  // A write accepted on the boundary cycle has pend_q=0, so it cannot be
  // applied until the following boundary.
  always_ff @(posedge io_mainClk) begin
    if (!io_resetn) begin
      pre_q         <= '0;
      cnt_q         <= '0;
      frame_q       <= 1'b0;
      pend_q        <= 1'b0;
      stage_ch_q    <= '0;
      stage_mode_q  <= MODE_OFF;
      stage_duty_q  <= '0;
      stage_blink_q <= '0;
    end else begin
      pre_q   <= tick ? '0 : pre_q + PRE_W'(1);
      if (tick) cnt_q <= cnt_q + PWM_WIDTH'(1);
      frame_q <= boundary;
      if (accept) begin
        pend_q        <= 1'b1;
        stage_ch_q    <= io_cfg_channel;
        stage_mode_q  <= led_mode_e'(io_cfg_mode);
        stage_duty_q  <= io_cfg_duty;
        stage_blink_q <= io_cfg_blink;
      end else if (boundary) begin
        pend_q <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    led_pwm_channel #(
      .PWM_WIDTH  (PWM_WIDTH),
      .BLINK_WIDTH(BLINK_WIDTH)
    ) u_ch (
      .clk_i       (io_mainClk),
      .rst_ni      (io_resetn),
      .frame_edge_i(boundary),
      .apply_i     (pend_q && (stage_ch_q == CW'(i))),
      .mode_i      (stage_mode_q),
      .duty_i      (stage_duty_q),
      .blink_i     (stage_blink_q),
      .cnt_i       (cnt_q),
      .led_o       (io_led[i])
    );
  end

  assign io_cfg_ready = !pend_q;
  assign io_frame     = frame_q;

endmodule

// File: tb/tb_led_pwm_bank.sv
// Randomized bench for led_pwm_bank against a frame-level behavioural model.
module tb_led_pwm_bank;

  localparam int CH = 6;
  localparam int PW = 4;
  localparam int BW = 4;
  localparam int CW = 3;
  localparam int FRAME = 2 ** PW;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          valid = 1'b0;
  logic          ready;
  logic [CW-1:0] chan = '0;
  logic [1:0]    mode = '0;
  logic [PW-1:0] duty = '0;
  logic [BW-1:0] blink = '0;
  logic [CH-1:0] led;
  logic          frame;

  always #5 clk = ~clk;

  led_pwm_bank #(
    .CHANNELS   (CH),
    .PWM_WIDTH  (PW),
    .PRESCALE   (1),
    .BLINK_WIDTH(BW)
  ) dut (
    .io_mainClk    (clk),
    .io_resetn     (rstn),
    .io_cfg_valid  (valid),
    .io_cfg_ready  (ready),
    .io_cfg_channel(chan),
    .io_cfg_mode   (mode),
    .io_cfg_duty   (duty),
    .io_cfg_blink  (blink),
    .io_led        (led),
    .io_frame      (frame)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: position in frame, per-channel config and frames elapsed since apply.
  int          m_cnt = 0;
  int          m_mode[CH];
  int          m_duty[CH];
  int          m_blink[CH];
  int          m_frames[CH];
  bit          m_pend = 0;
  int          s_ch, s_mode, s_duty, s_blink;
  logic [CH-1:0] m_led = '0;
  bit          m_frame = 0;

  task automatic model_edge();
    bit acc, ph;
    if (!rstn) begin
      m_cnt = 0; m_pend = 0; m_led = '0; m_frame = 0;
      for (int i = 0; i < CH; i++) begin
        m_mode[i] = 0; m_duty[i] = 0; m_blink[i] = 0; m_frames[i] = 0;
      end
      return;
    end
    for (int i = 0; i < CH; i++) begin
      ph = 1;
      if (m_mode[i] == 3 && m_blink[i] > 0) ph = ((m_frames[i] / m_blink[i]) % 2) == 0;
      case (m_mode[i])
        0:       m_led[i] = 1'b0;
        1:       m_led[i] = 1'b1;
        2:       m_led[i] = (m_cnt < m_duty[i]);
        default: m_led[i] = (m_cnt < m_duty[i]) && ph;
      endcase
    end
    m_frame = (m_cnt == FRAME - 1);
    acc = valid && !m_pend;
    if (m_frame) begin
      for (int i = 0; i < CH; i++) m_frames[i]++;
      if (m_pend && s_ch < CH) begin
        m_mode[s_ch] = s_mode; m_duty[s_ch] = s_duty;
        m_blink[s_ch] = s_blink; m_frames[s_ch] = 0;
      end
      m_pend = 0;
    end
    if (acc) begin
      m_pend = 1; s_ch = chan; s_mode = mode; s_duty = duty; s_blink = blink;
    end
    m_cnt = (m_cnt + 1) % FRAME;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("led", led, m_led);
    chk("frame", frame, m_frame);
    chk("ready", ready, !m_pend);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic put(input int c, input int m, input int d, input int b);
    bit acc;
    acc = 0;
    valid = 1'b1; chan = c[CW-1:0]; mode = m[1:0]; duty = d[PW-1:0]; blink = b[BW-1:0];
    for (int k = 0; k < 64 && !acc; k++) begin
      acc = ready;
      step();
    end
    valid = 1'b0;
    if (!acc) chk("put_timeout", 0, 1);
  endtask

  task automatic wait_frame();
    bit seen;
    seen = 0;
    for (int k = 0; k < 3 * FRAME && !seen; k++) begin
      step();
      seen = frame;
    end
    if (!seen) chk("frame_timeout", 0, 1);
  endtask

  task automatic count_on(input int ch, input int n, output int on);
    on = 0;
    repeat (n) begin
      step();
      if (led[ch]) on++;
    end
  endtask

  initial begin
    int on;
    // reset held with a pending-looking request
    rstn = 1'b0; valid = 1'b1; chan = 3'd2; mode = 2'd1;
    repeat (3) step();
    chk("rst_led", led, 0);
    chk("rst_frame", frame, 0);
    chk("rst_ready", ready, 1);
    valid = 1'b0; rstn = 1'b1;
    run(20);
    chk("rst_no_write", led, 0);

    // PWM duty 5 on ch2, then a second write held off while pending
    run(5);
    put(2, 2, 5, 0);
    valid = 1'b1; chan = 3'd3; mode = 2'd1;
    run(40);
    valid = 1'b0;
    wait_frame();
    count_on(2, FRAME, on);
    chk("pwm5_on", on, 5);

    // BLINK duty 15 blink 2: 2 frames of 15 on, 2 frames off
    put(0, 3, 15, 2);
    wait_frame();
    count_on(0, 4 * FRAME, on);
    chk("blink_on", on, 30);
    run(3 * FRAME);

    // out-of-range channel and duty 0
    put(7, 1, 0, 0);
    run(2 * FRAME);
    put(3, 2, 0, 0);
    run(2 * FRAME);
    chk("duty0_off", led[3], 0);

    // reset mid-pending drops the staged write
    put(1, 1, 0, 0);
    run(FRAME + 4);
    put(4, 1, 0, 0);
    run(2);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk("midrst_led", led, 0);
    run(3 * FRAME);
    chk("midrst_lost", led[4], 0);

    // random traffic
    repeat (3000) begin
      rstn  = ($urandom % 700) != 0;
      valid = ($urandom % 3) == 0;
      chan  = CW'($urandom % 8);
      mode  = 2'($urandom);
      duty  = PW'($urandom);
      blink = BW'($urandom % 5);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
